// File: rtl/regfile_param_sweep.sv
// regfile_param_sweep: DEPTH x WIDTH register file with two combinational
// read ports, optional same-cycle write-to-read bypass and a background clear
// sweep that zeroes one entry per cycle while holding off writes.
// Build option: define REGFILE_ZERO_REG_EN to hard-wire entry 0 to zero.
module regfile_param_sweep #(
  parameter  int WIDTH  = 16,
  parameter  int DEPTH  = 16,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             clr_req,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_acc;
  logic             wr_keep;
  logic             hit_a, hit_b;
  logic             zero_a, zero_b;

  assign wr_acc = wr_en && wr_ready;

`ifdef REGFILE_ZERO_REG_EN
  // Writes to entry 0 are handshaken normally but never land or forward.
  assign wr_keep = wr_acc && (wr_addr != '0);
  assign zero_a  = (rd_addr_a == '0);
  assign zero_b  = (rd_addr_b == '0);
`else
  assign wr_keep = wr_acc;
  assign zero_a  = 1'b0;
  assign zero_b  = 1'b0;
`endif

  // State register; reset always returns to IDLE, aborting any sweep.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: start sweep on clr_req, leave after the last entry.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_req) state_nxt = SWEEP;
      SWEEP:   if (cnt == AW'(DEPTH - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: writes are held off for the whole sweep.
  always_comb begin
    wr_ready = (state == IDLE);
    busy     = (state == SWEEP);
  end

  // Sweep pointer: parked at 0 in IDLE so a new sweep starts at entry 0.
  always_ff @(posedge clk) begin
    if (rst)                 cnt <= '0;
    else if (state == SWEEP) cnt <= cnt + AW'(1);
    else                     cnt <= '0;
  end

  // Storage: reset clears all, sweep clears one entry, otherwise accept writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == SWEEP) begin
      mem[cnt] <= '0;
    end else if (wr_keep) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Bypass hit detection, each port independent.
  always_comb begin
    hit_a = (BYPASS != 0) && wr_keep && (wr_addr == rd_addr_a);
    hit_b = (BYPASS != 0) && wr_keep && (wr_addr == rd_addr_b);
  end

  // Read muxes: forced zero, forwarded write data, or array contents.
  always_comb begin
    rd_data_a = zero_a ? '0 : (hit_a ? wr_data : mem[rd_addr_a]);
    rd_data_b = zero_b ? '0 : (hit_b ? wr_data : mem[rd_addr_b]);
  end

endmodule
